// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
//   Pipeline hazard control for a 5-stage in-order core: EX operand
//   forwarding selects, load-use stall detection, taken-branch flushes and a
//   two-state sequencer that holds the front of the pipe while a multi-cycle
//   mul/div executes.
//
//   Optional feature: define HAZARD_PERF_EN to add a saturating 32-bit
//   counter of cycles in which the PC was held (port perf_stall_cnt).
//
// Parameters
//   RW      register-address width
//   MD_LAT  mul/div execute latency in cycles (legal range 2..255)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_Ra, id_Rb               sources of the instruction in ID
//   ex_Ra, ex_Rb               sources of the instruction in EX
//   ex_Rw, ex_RegWr, ex_MemRd  destination / write enable / load flag in EX
//   mem_Rw, mem_RegWr          destination / write enable in MEM
//   wr_Rw, wr_RegWr            destination / write enable in WB
//   ex_md_start                mul/div entering EX this cycle
//   br_taken                   branch resolved taken in EX
//   forwardA, forwardB         EX operand select: 00 RF, 10 MEM, 01 WB
//   stall_pc, stall_id         hold PC and IF/ID
//   stall_ex                   hold ID/EX while mul/div runs
//   flush_id, flush_ex         zero IF/ID and ID/EX on the next edge
//   md_busy, md_done           mul/div in progress; one-cycle done pulse
//   perf_stall_cnt             (HAZARD_PERF_EN only) PC-stall cycle count
// ---------------------------------------------------------------------------
module hazard_unit #(
    parameter int RW     = 5,
    parameter int MD_LAT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [RW-1:0] id_Ra,
    input  logic [RW-1:0] id_Rb,
    input  logic [RW-1:0] ex_Ra,
    input  logic [RW-1:0] ex_Rb,
    input  logic [RW-1:0] ex_Rw,
    input  logic          ex_RegWr,
    input  logic          ex_MemRd,
    input  logic [RW-1:0] mem_Rw,
    input  logic          mem_RegWr,
    input  logic [RW-1:0] wr_Rw,
    input  logic          wr_RegWr,
    input  logic          ex_md_start,
    input  logic          br_taken,
    output logic [1:0]    forwardA,
    output logic [1:0]    forwardB,
    output logic          stall_pc,
    output logic          stall_id,
    output logic          stall_ex,
    output logic          flush_id,
    output logic          flush_ex,
    output logic          md_busy,
    output logic          md_done
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]   perf_stall_cnt
`endif
);

    localparam int CTR_W = $clog2(MD_LAT);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state;
    logic [CTR_W-1:0] ctr;
    logic             load_use;

    // MEM has the newer value, so it wins over WB. Register 0 is never
    // forwarded because it is hardwired to zero in the register file.
    function automatic logic [1:0] fwd_sel(input logic [RW-1:0] src);
        if (mem_RegWr && (mem_Rw != '0) && (mem_Rw == src))
            return 2'b10;
        else if (wr_RegWr && (wr_Rw != '0) && (wr_Rw == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign forwardA = fwd_sel(ex_Ra);
    assign forwardB = fwd_sel(ex_Rb);

    // Only a load that really writes a non-zero register can cause a bubble.
    // The hazard disappears on its own once the load moves to MEM, because
    // ex_MemRd then describes the bubble that followed it.
    assign load_use = ex_MemRd && ex_RegWr && (ex_Rw != '0) &&
                      ((ex_Rw == id_Ra) || (ex_Rw == id_Rb));

    assign md_busy = (state == BUSY);

    // Priority: an active mul/div freezes the front end and masks both the
    // branch and the load-use bubble (ID/EX is being held, so it must not be
    // flushed). Otherwise a taken branch kills the wrong-path instructions
    // and overrides any load-use stall on them.
    always_comb begin
        stall_pc = 1'b0;
        stall_id = 1'b0;
        stall_ex = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        if (state == BUSY) begin
            stall_pc = 1'b1;
            stall_id = 1'b1;
            stall_ex = 1'b1;
        end else if (br_taken) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else if (load_use) begin
            stall_pc = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
        end
    end

    // Mul/div sequencer: BUSY lasts MD_LAT-1 cycles after the start edge;
    // the cycle after that is the md_done cycle, with stalls released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ctr     <= '0;
            md_done <= 1'b0;
        end else begin
            md_done <= (state == BUSY) && (ctr == CTR_W'(1));
            case (state)
                IDLE: begin
                    if (ex_md_start) begin
                        state <= BUSY;
                        ctr   <= CTR_W'(MD_LAT - 1);
                    end
                end
                BUSY: begin
                    ctr <= ctr - CTR_W'(1);
                    if (ctr == CTR_W'(1))
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ctr   <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perf_stall_cnt <= '0;
        else if (stall_pc)
            perf_stall_cnt <= sat_inc32(perf_stall_cnt);
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit
//   Directed bench for hazard_unit (RW=5, MD_LAT=4). Inputs change 1 ns after
//   a rising edge; outputs are sampled 1 ns after the inputs settle.
//   Perf-counter checks are compiled in when HAZARD_PERF_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_Ra, id_Rb, ex_Ra, ex_Rb, ex_Rw, mem_Rw, wr_Rw;
    logic       ex_RegWr, ex_MemRd, mem_RegWr, wr_RegWr, ex_md_start, br_taken;
    logic [1:0] forwardA, forwardB;
    logic       stall_pc, stall_id, stall_ex, flush_id, flush_ex, md_busy, md_done;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_unit #(.RW(5), .MD_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_Ra(id_Ra), .id_Rb(id_Rb), .ex_Ra(ex_Ra), .ex_Rb(ex_Rb),
        .ex_Rw(ex_Rw), .ex_RegWr(ex_RegWr), .ex_MemRd(ex_MemRd),
        .mem_Rw(mem_Rw), .mem_RegWr(mem_RegWr),
        .wr_Rw(wr_Rw), .wr_RegWr(wr_RegWr),
        .ex_md_start(ex_md_start), .br_taken(br_taken),
        .forwardA(forwardA), .forwardB(forwardB),
        .stall_pc(stall_pc), .stall_id(stall_id), .stall_ex(stall_ex),
        .flush_id(flush_id), .flush_ex(flush_ex),
        .md_busy(md_busy), .md_done(md_done)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_Ra = 0; id_Rb = 0; ex_Ra = 0; ex_Rb = 0; ex_Rw = 0; mem_Rw = 0; wr_Rw = 0;
        ex_RegWr = 0; ex_MemRd = 0; mem_RegWr = 0; wr_RegWr = 0;
        ex_md_start = 0; br_taken = 0;
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packed view of control outputs: {stall_pc,stall_id,stall_ex,flush_id,flush_ex}
    function automatic logic [31:0] ctl();
        return {27'd0, stall_pc, stall_id, stall_ex, flush_id, flush_ex};
    endfunction

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #3;
        // Reset state
        chk("rst_md_busy", md_busy, 0);
        chk("rst_md_done", md_done, 0);
        chk("rst_ctl", ctl(), 0);
        chk("rst_fwdA", forwardA, 0);
`ifdef HAZARD_PERF_EN
        chk("rst_perf", perf_stall_cnt, 0);
`endif
        step(); step();
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", md_busy, 0);

        // Forwarding priority MEM > WB > RF
        ex_Ra = 3; mem_Rw = 3; mem_RegWr = 1; wr_Rw = 3; wr_RegWr = 1; #1;
        chk("fwdA_mem", forwardA, 2'b10);
        mem_RegWr = 0; #1;
        chk("fwdA_wb", forwardA, 2'b01);
        ex_Ra = 0; mem_Rw = 0; #1;
        chk("fwdA_none", forwardA, 2'b00);
        wr_Rw = 0; mem_RegWr = 1; #1;
        chk("fwdA_r0", forwardA, 2'b00);
        ex_Rb = 7; mem_Rw = 7; #1;
        chk("fwdB_mem", forwardB, 2'b10);
        mem_RegWr = 0; wr_Rw = 7; #1;
        chk("fwdB_wb", forwardB, 2'b01);
        chk("fwd_no_ctl", ctl(), 0);
        clear_inputs();

        // Load-use on id_Rb
        step();
        ex_MemRd = 1; ex_RegWr = 1; ex_Rw = 5; id_Rb = 5; #1;
        chk("lu_ctl", ctl(), 5'b11001);
        step();
        // Load now in MEM, dependent instruction in EX, bubble ahead of it
        clear_inputs();
        mem_Rw = 5; mem_RegWr = 1; ex_Rb = 5; #1;
        chk("lu_next_ctl", ctl(), 0);
        chk("lu_next_fwdB", forwardB, 2'b10);
        clear_inputs();
        ex_MemRd = 1; ex_RegWr = 1; ex_Rw = 0; id_Ra = 0; #1;
        chk("lu_r0_ctl", ctl(), 0);
        ex_Rw = 9; id_Ra = 9; ex_RegWr = 0; #1;
        chk("lu_noregwr_ctl", ctl(), 0);

        // Branch overrides load-use
        ex_RegWr = 1; br_taken = 1; #1;
        chk("br_lu_ctl", ctl(), 5'b00011);
        clear_inputs();

        // Mul/div operation with an ignored second start and ignored branch
        step();
        ex_md_start = 1;
        step();
        ex_md_start = 0; #1;
        chk("md_c1_busy", md_busy, 1);
        chk("md_c1_ctl", ctl(), 5'b11100);
        step();
        ex_md_start = 1; br_taken = 1; #1;
        chk("md_c2_busy", md_busy, 1);
        chk("md_c2_br_ctl", ctl(), 5'b11100);
        step();
        ex_md_start = 0; br_taken = 0; #1;
        chk("md_c3_busy", md_busy, 1);
        chk("md_c3_done", md_done, 0);
        step();
        chk("md_c4_busy", md_busy, 0);
        chk("md_c4_done", md_done, 1);
        chk("md_c4_ctl", ctl(), 0);
        step();
        chk("md_c5_busy", md_busy, 0);
        chk("md_c5_done", md_done, 0);

        // Start together with branch in IDLE: flush and still go BUSY
        ex_md_start = 1; br_taken = 1; #1;
        chk("start_br_ctl", ctl(), 5'b00011);
        step();
        clear_inputs(); #1;
        chk("start_br_busy", md_busy, 1);
        step();
        chk("abort_c2_busy", md_busy, 1);
        #2;
        rst_n = 1'b0; #1;
        chk("abort_busy_async", md_busy, 0);
        chk("abort_ctl", ctl(), 0);
        chk("abort_done", md_done, 0);
`ifdef HAZARD_PERF_EN
        chk("abort_perf", perf_stall_cnt, 0);
`endif
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_no_done", md_done, 0);
            chk("abort_idle", md_busy, 0);
        end

`ifdef HAZARD_PERF_EN
        // Full operation counts MD_LAT-1 stalled cycles
        chk("perf_start", perf_stall_cnt, 0);
        ex_md_start = 1;
        step();
        ex_md_start = 0;
        step(); step(); step();
        chk("perf_done", md_done, 1);
        chk("perf_cnt3", perf_stall_cnt, 3);
        step();
        chk("perf_hold", perf_stall_cnt, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter RW, default 5: register-address width.
REQ-002 Parameter MD_LAT, default 4: mul/div execute latency in cycles; legal range 2..255.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 id_Ra, id_Rb  in  RW each  source registers of the instruction in ID.
REQ-006 ex_Ra, ex_Rb  in  RW each  source registers of the instruction in EX.
REQ-007 ex_Rw, ex_RegWr, ex_MemRd  in  RW/1/1  destination register, write enable and load flag of the instruction in EX.
REQ-008 mem_Rw, mem_RegWr  in  RW/1  destination register and write enable in MEM.
REQ-009 wr_Rw, wr_RegWr  in  RW/1  destination register and write enable in WB.
REQ-010 ex_md_start  in  1  a mul/div instruction is entering EX this cycle.
REQ-011 br_taken  in  1  branch resolved taken in EX.
REQ-012 forwardA, forwardB  out  2 each  EX operand mux select: 00 register file, 10 MEM result, 01 WB result.
REQ-013 stall_pc, stall_id  out  1 each  hold PC and IF/ID register.
REQ-014 stall_ex  out  1  hold ID/EX register (mul/div in progress).
REQ-015 flush_id, flush_ex  out  1 each  zero IF/ID and ID/EX on the next edge.
REQ-016 md_busy, md_done  out  1 each  mul/div in progress; one-cycle completion pulse.

Function
REQ-017 forwardA SHALL be 10 when mem_RegWr=1, mem_Rw!=0 and mem_Rw==ex_Ra; otherwise 01 when wr_RegWr=1, wr_Rw!=0 and wr_Rw==ex_Ra; otherwise 00. forwardB SHALL use the same rule against ex_Rb.
REQ-018 A load-use hazard SHALL be detected when ex_MemRd=1, ex_RegWr=1, ex_Rw!=0, and ex_Rw equals id_Ra or id_Rb.
REQ-019 On a load-use hazard, the block SHALL assert stall_pc=stall_id=flush_ex=1 combinationally for that cycle only; no repeat stall once the load advances to MEM.
REQ-020 The mul/div FSM SHALL have two states, IDLE and BUSY, with a down-counter ctr of width ceil(log2(MD_LAT)).
REQ-021 IDLE with ex_md_start=1: next state BUSY, ctr loaded with MD_LAT-1.
REQ-022 While in BUSY: md_busy=1, stall_pc=stall_id=stall_ex=1, and ctr decrements by 1 each cycle.
REQ-023 BUSY with ctr==1: on the next edge, go to IDLE, pulse md_done=1 for exactly one cycle, and release stalls in that cycle.
REQ-024 ex_md_start SHALL be ignored while in BUSY.
REQ-025 When br_taken=1 and FSM is IDLE, the block SHALL assert flush_id=flush_ex=1 and force stall_pc=stall_id=0 (branch overrides load-use).
REQ-026 br_taken SHALL be ignored while in BUSY.
REQ-027 ex_md_start and br_taken both high in IDLE: branch flush applies and the FSM still enters BUSY.
REQ-028 All outputs other than md_busy, md_done and perf_stall_cnt SHALL be combinational; the FSM outputs SHALL be registered-state decodes.

Reset
REQ-029 While rst_n=0: FSM=IDLE, ctr=0, md_done=0, perf_stall_cnt=0; combinational outputs follow their inputs with FSM=IDLE.
REQ-030 Reset assertion mid-BUSY SHALL abort the operation immediately with no md_done pulse.

Configuration
REQ-031 Macro HAZARD_PERF_EN defined: output perf_stall_cnt (32 bits) SHALL be present; it increments each cycle stall_pc=1, saturates at 0xFFFFFFFF, and clears on reset.
REQ-032 Macro HAZARD_PERF_EN undefined: neither the port nor the counter logic SHALL exist; all other behaviour is identical.

Verification
REQ-033 ex_Ra=3, mem_Rw=3, mem_RegWr=1, wr_Rw=3, wr_RegWr=1 -> forwardA=10; set mem_RegWr=0 -> forwardA=01; set ex_Ra=0 with mem_Rw=0 -> forwardA=00.
REQ-034 Load-use: ex_MemRd=1, ex_RegWr=1, ex_Rw=5, id_Rb=5 -> stall_pc=stall_id=flush_ex=1 for one cycle; next cycle (load in MEM) -> stalls 0 and forwardB=10.
REQ-035 MD_LAT=4, pulse ex_md_start -> md_busy and stall_ex high for cycles 1-3 after the start edge, md_done=1 on cycle 4, no stall on cycle 4; a second ex_md_start at cycle 2 has no effect.
REQ-036 br_taken=1 coincident with a load-use hazard -> flush_id=flush_ex=1, stall_pc=0; with br_taken=1 in BUSY -> no flush.
REQ-037 rst_n low at cycle 2 of a BUSY operation -> md_busy=0 asynchronously and no md_done; with HAZARD_PERF_EN, perf_stall_cnt reads 0 after reset and counts 3 after a full MD_LAT=4 operation.
